lsu_byte_sequencer: RTL and testbench



---
 rtl/lsu_byte_sequencer.sv | 174 +++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer
// -------------------
// Load/store sequencer between the execute stage and a byte-wide data memory
// port. One LB/LH/LW/LBU/LHU/SB/SH/SW request is accepted at a time. It is
// split into 1, 2 or 4 byte transfers on the memory port. Load bytes are
// assembled little-endian, then sign- or zero-extended, and the result is
// returned as a single-cycle response.
//
// Handshakes: a transfer on req_* or mem_* happens on a rising clk edge where
// valid and ready are both high. The valid side holds its payload stable
// until that edge. Ready may depend on the state only.
//
// Ports
//   clk, rst      clock (rising edge); synchronous active-high reset
//   req_*         request from execute (valid/ready, we, funct3, addr, wdata)
//   mem_*         byte memory port (valid/ready, we, addr, wdata, rdata);
//                 mem_rdata must be valid in the cycle mem_ready is high
//   resp_*        one-cycle completion pulse, error flag, extended load data
//   dbg_state     current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned
// halfword/word requests with resp_err instead of servicing them byte-serially.

module lsu_byte_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        idx;
  logic [31:0]       ld_buf;
  logic              err_q;
  logic              legal;
  logic [1:0]        last_idx;
  logic              accept;
  logic              xfer;

  assign accept = (state == IDLE) && req_valid;
  assign xfer   = (state == ACCESS) && mem_ready;

  // Request legality. This only steers the next state and the latched error
  // flag, so nothing on req_* reaches the memory port combinationally.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      legal = 1'b0;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      legal = 1'b0;
`endif
  end

  // Index of the final byte of the latched access. Only sizes 00/01/10
  // ever reach ACCESS.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = legal ? ACCESS : RESP;
      ACCESS:  if (mem_ready && idx == last_idx) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      idx      <= 2'd0;
      ld_buf   <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        idx      <= 2'd0;
        ld_buf   <= 32'h0;
        err_q    <= ~legal;
      end
      if (xfer) begin
        if (!we_q)
          ld_buf[{idx, 3'b000} +: 8] <= mem_rdata;
        idx <= idx + 2'd1;
      end
    end
  end

  // All outputs are decoded from the state register and latched fields.
  always_comb begin
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        // Linear byte addressing; wraps naturally at 2^ADDR_W.
        mem_addr  = addr_q + ADDR_W'(idx);
        mem_wdata = wdata_q[{idx, 3'b000} +: 8];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) begin
          case (funct3_q)
            3'b000:  resp_rdata = {{24{ld_buf[7]}}, ld_buf[7:0]};
            3'b001:  resp_rdata = {{16{ld_buf[15]}}, ld_buf[15:0]};
            3'b010:  resp_rdata = ld_buf;
            3'b100:  resp_rdata = {24'h0, ld_buf[7:0]};
            3'b101:  resp_rdata = {16'h0, ld_buf[15:0]};
            default: resp_rdata = 32'h0;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed testbench for lsu_byte_sequencer: byte memory model, transfer
// address log, and a linear sequence of checked steps.

module tb_lsu_byte_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  lsu_byte_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dbg_state(dbg_state)
  );

  // Memory model: read image written only by the stimulus block, write image
  // and transfer address log written only by the monitor.
  logic [7:0]  mem [0:255];
  logic [7:0]  wr_mem [0:255];
  logic [31:0] addr_log [$];
  int          log_base;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_valid && mem_ready) begin
      if (mem_we) wr_mem[mem_addr[7:0]] <= mem_wdata;
      addr_log.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE and waits (bounded) for its response.
  // cyc = cycle of resp_valid counting the accept edge as 0; on return the
  // bench sits in cycle cyc+1.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int cyc, output logic [31:0] rdata,
                         output logic err, output int nxf, output logic busy_rdy);
    log_base   = addr_log.size();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid = 1'b0;
    cyc       = 1;
    busy_rdy  = 1'b0;
    while (!resp_valid && cyc < 64) begin
      busy_rdy = busy_rdy | req_ready;
      step();
      cyc++;
    end
    busy_rdy = busy_rdy | req_ready;
    rdata    = resp_rdata;
    err      = resp_err;
    step();
    nxf = addr_log.size() - log_base;
  endtask

  int          cyc;
  int          nxf;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    mem[8'h06] = 8'h7F; mem[8'h07] = 8'h80;
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2;
    mem[8'h00] = 8'hC3;
    // 0x100..0x103 alias to 0x00..0x03 in the 256-byte model, so the LW
    // test and the wrap test use distinct images set just before each.
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b1;
    repeat (3) step();

    // Reset values
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);
    rst = 1'b0;
    step();

    // LW 0x100 -> 4 transfers, resp in cycle 5
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    run_req(1'b0, 3'b010, 32'h100, 32'h0, cyc, rdata, err, nxf, busy);
    chk("lw_resp_cycle", cyc, 32'd5);
    chk("lw_rdata", rdata, 32'h44332211);
    chk("lw_err", {31'h0, err}, 32'd0);
    chk("lw_nxfer", nxf, 32'd4);
    for (int i = 0; i < 4 && i < nxf; i++)
      chk("lw_addr", addr_log[log_base + i], 32'h100 + i);
    chk("lw_busy_ready", {31'h0, busy}, 32'd0);
    chk("lw_ready_after", {31'h0, req_ready}, 32'd1);

    // LB / LBU / LH / LHU
    run_req(1'b0, 3'b000, 32'h7, 32'h0, cyc, rdata, err, nxf, busy);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_resp_cycle", cyc, 32'd2);
    chk("lb_addr", addr_log[log_base], 32'h7);
    run_req(1'b0, 3'b100, 32'h7, 32'h0, cyc, rdata, err, nxf, busy);
    chk("lbu_rdata", rdata, 32'h00000080);
    mem[8'h07] = 8'hF0;
    run_req(1'b0, 3'b101, 32'h6, 32'h0, cyc, rdata, err, nxf, busy);
    chk("lhu_rdata", rdata, 32'h0000F07F);
    chk("lhu_resp_cycle", cyc, 32'd3);
    run_req(1'b0, 3'b001, 32'h6, 32'h0, cyc, rdata, err, nxf, busy);
    chk("lh_rdata", rdata, 32'hFFFFF07F);

    // SH 0x20 with 3 stall cycles on the first byte
    mem_ready  = 1'b0;
    log_base   = addr_log.size();
    req_valid  = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr   = 32'h20; req_wdata = 32'hAABBCCDD;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh_stall_valid", {31'h0, mem_valid}, 32'd1);
      chk("sh_stall_we", {31'h0, mem_we}, 32'd1);
      chk("sh_stall_addr", mem_addr, 32'h20);
      chk("sh_stall_wdata", {24'h0, mem_wdata}, 32'hDD);
      chk("sh_stall_ready", {31'h0, req_ready}, 32'd0);
      step();
    end
    mem_ready = 1'b1;
    chk("sh_b0_addr", mem_addr, 32'h20);
    chk("sh_b0_wdata", {24'h0, mem_wdata}, 32'hDD);
    step();
    chk("sh_b1_addr", mem_addr, 32'h21);
    chk("sh_b1_wdata", {24'h0, mem_wdata}, 32'hCC);
    chk("sh_b1_ready", {31'h0, req_ready}, 32'd0);
    step();
    chk("sh_resp_valid", {31'h0, resp_valid}, 32'd1);
    chk("sh_resp_rdata", resp_rdata, 32'h0);
    chk("sh_resp_err", {31'h0, resp_err}, 32'd0);
    chk("sh_resp_ready", {31'h0, req_ready}, 32'd0);
    step();
    chk("sh_resp_pulse", {31'h0, resp_valid}, 32'd0);
    chk("sh_ready_after", {31'h0, req_ready}, 32'd1);
    chk("sh_nxfer", addr_log.size() - log_base, 32'd2);
    chk("sh_mem20", {24'h0, wr_mem[8'h20]}, 32'hDD);
    chk("sh_mem21", {24'h0, wr_mem[8'h21]}, 32'hCC);

    // SB 0x30
    run_req(1'b1, 3'b000, 32'h30, 32'h1234565A, cyc, rdata, err, nxf, busy);
    chk("sb_resp_cycle", cyc, 32'd2);
    chk("sb_rdata", rdata, 32'h0);
    step();
    chk("sb_mem30", {24'h0, wr_mem[8'h30]}, 32'h5A);

    // Illegal funct3: load 011, store 100
    run_req(1'b0, 3'b011, 32'h40, 32'h0, cyc, rdata, err, nxf, busy);
    chk("ill_ld_cycle", cyc, 32'd1);
    chk("ill_ld_err", {31'h0, err}, 32'd1);
    chk("ill_ld_rdata", rdata, 32'h0);
    chk("ill_ld_nxfer", nxf, 32'd0);
    run_req(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, cyc, rdata, err, nxf, busy);
    chk("ill_st_err", {31'h0, err}, 32'd1);
    chk("ill_st_nxfer", nxf, 32'd0);

    // LW at 0xFFFFFFFE: wraps, or traps when misalignment is rejected
    mem[8'h00] = 8'hC3; mem[8'h01] = 8'hD4;
    run_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, cyc, rdata, err, nxf, busy);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("wrap_err", {31'h0, err}, 32'd1);
    chk("wrap_nxfer", nxf, 32'd0);
    chk("wrap_cycle", cyc, 32'd1);
`else
    chk("wrap_err", {31'h0, err}, 32'd0);
    chk("wrap_nxfer", nxf, 32'd4);
    if (nxf == 4) begin
      chk("wrap_addr0", addr_log[log_base], 32'hFFFFFFFE);
      chk("wrap_addr1", addr_log[log_base + 1], 32'hFFFFFFFF);
      chk("wrap_addr2", addr_log[log_base + 2], 32'h00000000);
      chk("wrap_addr3", addr_log[log_base + 3], 32'h00000001);
    end
    chk("wrap_rdata", rdata, 32'hD4C3B2A1);
`endif

    // Reset after the 2nd transfer of an LW
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("rmid_addr", mem_addr, 32'h102);
    rst = 1'b1;
    step();
    chk("rmid_ready", {31'h0, req_ready}, 32'd1);
    chk("rmid_mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("rmid_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rmid_state", {30'h0, dbg_state}, 32'd0);
    rst = 1'b0;
    step();
    chk("rmid_resp_valid2", {31'h0, resp_valid}, 32'd0);
    chk("rmid_mem_valid2", {31'h0, mem_valid}, 32'd0);
    run_req(1'b0, 3'b000, 32'h100, 32'h0, cyc, rdata, err, nxf, busy);
    chk("rmid_lb_rdata", rdata, 32'h00000011);
    chk("rmid_lb_cycle", cyc, 32'd2);
    chk("rmid_lb_err", {31'h0, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
